// File: rtl/sent_rx_store_arb.sv
// SENT receiver store-FIFO write arbiter: one pending slot per source, tagged 12-bit words, round-robin grant.
// Optional CRC gating of items via `define SENT_RX_STORE_CRC_GATE_EN.
module sent_rx_store_arb (
   input  logic        clk_rx,
   input  logic        reset_n_rx,
   input  logic        enable_i,
   input  logic        fast_valid_i,
   input  logic [1:0]  fast_fmt_i,
   input  logic [23:0] fast_data_i,
   input  logic        fast_crc_ok_i,
   input  logic        slow_valid_i,
   input  logic [7:0]  slow_id_i,
   input  logic [15:0] slow_data_i,
   input  logic        slow_crc_ok_i,
   input  logic        fifo_full_i,
   output logic        fifo_wr_en_o,
   output logic [13:0] fifo_data_o,
   output logic        busy_o,
   output logic [7:0]  crc_err_cnt_o,
   output logic [7:0]  drop_cnt_o
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FAST_W0 = 3'd1;
   localparam logic [2:0] ST_FAST_W1 = 3'd2;
   localparam logic [2:0] ST_SLOW_W0 = 3'd3;
   localparam logic [2:0] ST_SLOW_W1 = 3'd4;

   localparam logic RR_FAST = 1'b0;
   localparam logic RR_SLOW = 1'b1;

   function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, cnt} + {7'b0, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   logic [2:0]  state, state_nxt;
   logic        rr, rr_nxt;
   logic        fast_vld_p0, slow_vld_p0;
   logic [1:0]  fast_fmt_p0;
   logic [23:0] fast_data_p0;
   logic [7:0]  slow_id_p0;
   logic [15:0] slow_data_p0;
   logic        wr_nxt;
   logic [13:0] word_nxt;

   logic fast_two, fast_free, slow_free;
   logic fast_req, slow_req, fast_bad_fmt;
   logic fast_crc_bad, slow_crc_bad;
   logic fast_load, slow_load, fast_drop, slow_drop;

   assign fast_two  = (fast_fmt_p0 == 2'b01);
   assign fast_free = !fifo_full_i && ((state == ST_FAST_W0 && !fast_two) || state == ST_FAST_W1);
   assign slow_free = !fifo_full_i && (state == ST_SLOW_W1);

   assign fast_req     = enable_i && fast_valid_i;
   assign slow_req     = enable_i && slow_valid_i;
   assign fast_bad_fmt = (fast_fmt_i == 2'b00);

`ifdef SENT_RX_STORE_CRC_GATE_EN
   assign fast_crc_bad = fast_req && !fast_bad_fmt && !fast_crc_ok_i;
   assign slow_crc_bad = slow_req && !slow_crc_ok_i;
`else
   logic crc_unused;
   assign crc_unused   = fast_crc_ok_i ^ slow_crc_ok_i;
   assign fast_crc_bad = 1'b0;
   assign slow_crc_bad = 1'b0;
`endif

   // A slot freeing in this cycle can be reloaded at the same edge
   assign fast_load = fast_req && !fast_bad_fmt && !fast_crc_bad && (!fast_vld_p0 || fast_free);
   assign slow_load = slow_req && !slow_crc_bad && (!slow_vld_p0 || slow_free);
   assign fast_drop = fast_req && !fast_crc_bad && !fast_load;
   assign slow_drop = slow_req && !slow_crc_bad && !slow_load;

   always_comb begin
      state_nxt = state;
      rr_nxt    = rr;
      wr_nxt    = 1'b0;
      word_nxt  = fifo_data_o;
      case (state)
         ST_IDLE: begin
            if (fast_vld_p0 && (!slow_vld_p0 || rr == RR_FAST)) state_nxt = ST_FAST_W0;
            else if (slow_vld_p0)                              state_nxt = ST_SLOW_W0;
         end
         ST_FAST_W0: if (!fifo_full_i) begin
            wr_nxt   = 1'b1;
            word_nxt = {2'b00, fast_two ? fast_data_p0[23:12] : fast_data_p0[11:0]};
            if (fast_two) state_nxt = ST_FAST_W1;
            else begin
               state_nxt = ST_IDLE;
               rr_nxt    = RR_SLOW;
            end
         end
         ST_FAST_W1: if (!fifo_full_i) begin
            wr_nxt    = 1'b1;
            word_nxt  = {2'b01, fast_data_p0[11:0]};
            state_nxt = ST_IDLE;
            rr_nxt    = RR_SLOW;
         end
         ST_SLOW_W0: if (!fifo_full_i) begin
            wr_nxt    = 1'b1;
            word_nxt  = {2'b10, slow_id_p0, slow_data_p0[15:12]};
            state_nxt = ST_SLOW_W1;
         end
         ST_SLOW_W1: if (!fifo_full_i) begin
            wr_nxt    = 1'b1;
            word_nxt  = {2'b11, slow_data_p0[11:0]};
            state_nxt = ST_IDLE;
            rr_nxt    = RR_FAST;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Stage p0: pending-slot occupancy and control
   always_ff @(posedge clk_rx or negedge reset_n_rx) begin
      if (!reset_n_rx) begin
         state        <= ST_IDLE;
         rr           <= RR_FAST;
         fast_vld_p0  <= 1'b0;
         slow_vld_p0  <= 1'b0;
         fifo_wr_en_o <= 1'b0;
         fifo_data_o  <= '0;
         drop_cnt_o   <= '0;
      end else begin
         state        <= state_nxt;
         rr           <= rr_nxt;
         fast_vld_p0  <= fast_load || (fast_vld_p0 && !fast_free);
         slow_vld_p0  <= slow_load || (slow_vld_p0 && !slow_free);
         fifo_wr_en_o <= wr_nxt;
         fifo_data_o  <= word_nxt;
         drop_cnt_o   <= sat_add(drop_cnt_o, {1'b0, fast_drop} + {1'b0, slow_drop});
      end
   end

   always_ff @(posedge clk_rx) begin
      if (fast_load) begin
         fast_fmt_p0  <= fast_fmt_i;
         fast_data_p0 <= fast_data_i;
      end
      if (slow_load) begin
         slow_id_p0   <= slow_id_i;
         slow_data_p0 <= slow_data_i;
      end
   end

`ifdef SENT_RX_STORE_CRC_GATE_EN
   always_ff @(posedge clk_rx or negedge reset_n_rx) begin
      if (!reset_n_rx) crc_err_cnt_o <= '0;
      else             crc_err_cnt_o <= sat_add(crc_err_cnt_o, {1'b0, fast_crc_bad} + {1'b0, slow_crc_bad});
   end
`else
   assign crc_err_cnt_o = 8'h00;
`endif

   assign busy_o = (state != ST_IDLE) || fast_vld_p0 || slow_vld_p0;

endmodule

// File: tb/tb_sent_rx_store_arb.sv
// Directed bench for sent_rx_store_arb; each task drives one scenario and checks cycle-exact outputs.
module tb_sent_rx_store_arb;

   logic        clk_rx = 1'b0;
   logic        reset_n_rx = 1'b0;
   logic        enable_i = 1'b0;
   logic        fast_valid_i = 1'b0;
   logic [1:0]  fast_fmt_i = 2'b00;
   logic [23:0] fast_data_i = '0;
   logic        fast_crc_ok_i = 1'b1;
   logic        slow_valid_i = 1'b0;
   logic [7:0]  slow_id_i = '0;
   logic [15:0] slow_data_i = '0;
   logic        slow_crc_ok_i = 1'b1;
   logic        fifo_full_i = 1'b0;
   logic        fifo_wr_en_o;
   logic [13:0] fifo_data_o;
   logic        busy_o;
   logic [7:0]  crc_err_cnt_o;
   logic [7:0]  drop_cnt_o;

   int n_total = 0;
   int n_pass  = 0;

   sent_rx_store_arb dut (
      .clk_rx(clk_rx), .reset_n_rx(reset_n_rx), .enable_i(enable_i),
      .fast_valid_i(fast_valid_i), .fast_fmt_i(fast_fmt_i), .fast_data_i(fast_data_i),
      .fast_crc_ok_i(fast_crc_ok_i), .slow_valid_i(slow_valid_i), .slow_id_i(slow_id_i),
      .slow_data_i(slow_data_i), .slow_crc_ok_i(slow_crc_ok_i), .fifo_full_i(fifo_full_i),
      .fifo_wr_en_o(fifo_wr_en_o), .fifo_data_o(fifo_data_o), .busy_o(busy_o),
      .crc_err_cnt_o(crc_err_cnt_o), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk_rx = ~clk_rx;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk_rx);
      #1;
   endtask

   task automatic do_reset;
      reset_n_rx = 1'b0;
      enable_i = 1'b1; fast_valid_i = 1'b0; slow_valid_i = 1'b0; fifo_full_i = 1'b0;
      fast_crc_ok_i = 1'b1; slow_crc_ok_i = 1'b1;
      tick; tick;
      reset_n_rx = 1'b1;
      tick;
   endtask

   task automatic test_reset;
      reset_n_rx = 1'b0;
      tick;
      n_total++; if (fifo_wr_en_o !== 1'b0) $display("FAIL rst_wr: got %b want 0", fifo_wr_en_o); else n_pass++;
      n_total++; if (fifo_data_o !== 14'h0) $display("FAIL rst_data: got %h want 0000", fifo_data_o); else n_pass++;
      n_total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else n_pass++;
      n_total++; if (crc_err_cnt_o !== 8'h00) $display("FAIL rst_crc: got %h want 00", crc_err_cnt_o); else n_pass++;
      n_total++; if (drop_cnt_o !== 8'h00) $display("FAIL rst_drop: got %h want 00", drop_cnt_o); else n_pass++;
   endtask

   task automatic test_two_word;
      do_reset;
      fast_valid_i = 1'b1; fast_fmt_i = 2'b01; fast_data_i = 24'hABC123;
      tick;
      fast_valid_i = 1'b0;
      n_total++; if (busy_o !== 1'b1) $display("FAIL two_busy: got %b want 1", busy_o); else n_pass++;
      tick;
      n_total++; if (fifo_wr_en_o !== 1'b0) $display("FAIL two_grant_wr: got %b want 0", fifo_wr_en_o); else n_pass++;
      tick;
      n_total++; if ({fifo_wr_en_o, fifo_data_o} !== {1'b1, 14'h0ABC}) $display("FAIL two_w0: got %b/%h want 1/0abc", fifo_wr_en_o, fifo_data_o); else n_pass++;
      tick;
      n_total++; if ({fifo_wr_en_o, fifo_data_o} !== {1'b1, 14'h1123}) $display("FAIL two_w1: got %b/%h want 1/1123", fifo_wr_en_o, fifo_data_o); else n_pass++;
      tick;
      n_total++; if ({fifo_wr_en_o, fifo_data_o} !== {1'b0, 14'h1123}) $display("FAIL two_after: got %b/%h want 0/1123", fifo_wr_en_o, fifo_data_o); else n_pass++;
      n_total++; if (busy_o !== 1'b0) $display("FAIL two_idle_busy: got %b want 0", busy_o); else n_pass++;
   endtask

   task automatic test_back_to_back;
      logic [14:0] exp_a [0:5];
      logic [14:0] exp_b [0:4];
      do_reset;
      exp_a[0] = {1'b0, 14'h0}; exp_a[1] = {1'b1, 14'h0456}; exp_a[2] = {1'b0, 14'h0456};
      exp_a[3] = {1'b1, 14'h25A7}; exp_a[4] = {1'b1, 14'h3F01}; exp_a[5] = {1'b0, 14'h3F01};
      fast_valid_i = 1'b1; fast_fmt_i = 2'b10; fast_data_i = 24'h000456;
      slow_valid_i = 1'b1; slow_id_i = 8'h5A; slow_data_i = 16'h7F01;
      tick;
      fast_valid_i = 1'b0; slow_valid_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick;
         n_total++; if ({fifo_wr_en_o, fifo_data_o} !== exp_a[i]) $display("FAIL pair1_c%0d: got %b/%h want %b/%h", i, fifo_wr_en_o, fifo_data_o, exp_a[i][14], exp_a[i][13:0]); else n_pass++;
      end
      // lone fast item between the pairs
      fast_valid_i = 1'b1; fast_fmt_i = 2'b11; fast_data_i = 24'h000789;
      tick;
      fast_valid_i = 1'b0;
      tick; tick;
      n_total++; if ({fifo_wr_en_o, fifo_data_o} !== {1'b1, 14'h0789}) $display("FAIL lone_w0: got %b/%h want 1/0789", fifo_wr_en_o, fifo_data_o); else n_pass++;
      tick; tick;
      exp_b[0] = {1'b0, 14'h0789}; exp_b[1] = {1'b1, 14'h2031}; exp_b[2] = {1'b1, 14'h3234};
      exp_b[3] = {1'b0, 14'h3234}; exp_b[4] = {1'b1, 14'h0321};
      fast_valid_i = 1'b1; fast_fmt_i = 2'b10; fast_data_i = 24'h000321;
      slow_valid_i = 1'b1; slow_id_i = 8'h03; slow_data_i = 16'h1234;
      tick;
      fast_valid_i = 1'b0; slow_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         n_total++; if ({fifo_wr_en_o, fifo_data_o} !== exp_b[i]) $display("FAIL pair2_c%0d: got %b/%h want %b/%h", i, fifo_wr_en_o, fifo_data_o, exp_b[i][14], exp_b[i][13:0]); else n_pass++;
      end
      tick;
      n_total++; if (busy_o !== 1'b0) $display("FAIL pair2_busy: got %b want 0", busy_o); else n_pass++;
   endtask

   task automatic test_fifo_full;
      do_reset;
      slow_valid_i = 1'b1; slow_id_i = 8'hA5; slow_data_i = 16'hC123;
      tick;
      slow_valid_i = 1'b0;
      tick; tick;
      n_total++; if ({fifo_wr_en_o, fifo_data_o} !== {1'b1, 14'h2A5C}) $display("FAIL full_w0: got %b/%h want 1/2a5c", fifo_wr_en_o, fifo_data_o); else n_pass++;
      fifo_full_i = 1'b1;
      fast_valid_i = 1'b1; fast_fmt_i = 2'b10; fast_data_i = 24'h000999;
      for (int i = 0; i < 5; i++) begin
         tick;
         fast_valid_i = 1'b0;
         n_total++; if ({fifo_wr_en_o, fifo_data_o} !== {1'b0, 14'h2A5C}) $display("FAIL full_hold_c%0d: got %b/%h want 0/2a5c", i, fifo_wr_en_o, fifo_data_o); else n_pass++;
      end
      fifo_full_i = 1'b0;
      tick;
      n_total++; if ({fifo_wr_en_o, fifo_data_o} !== {1'b1, 14'h3123}) $display("FAIL full_w1: got %b/%h want 1/3123", fifo_wr_en_o, fifo_data_o); else n_pass++;
      tick;
      n_total++; if (fifo_wr_en_o !== 1'b0) $display("FAIL full_gap: got %b want 0", fifo_wr_en_o); else n_pass++;
      tick;
      n_total++; if ({fifo_wr_en_o, fifo_data_o} !== {1'b1, 14'h0999}) $display("FAIL full_fast: got %b/%h want 1/0999", fifo_wr_en_o, fifo_data_o); else n_pass++;
   endtask

   task automatic test_drops;
      do_reset;
      fifo_full_i = 1'b1;
      fast_valid_i = 1'b1; fast_fmt_i = 2'b10; fast_data_i = 24'h000111;
      tick; tick; tick;
      fast_valid_i = 1'b0;
      tick;
      n_total++; if (drop_cnt_o !== 8'd2) $display("FAIL drop_three: got %0d want 2", drop_cnt_o); else n_pass++;
      n_total++; if (fifo_wr_en_o !== 1'b0) $display("FAIL drop_nowr: got %b want 0", fifo_wr_en_o); else n_pass++;
      slow_valid_i = 1'b1; slow_id_i = 8'h11; slow_data_i = 16'h2222;
      tick;
      fast_valid_i = 1'b1;
      tick;
      fast_valid_i = 1'b0; slow_valid_i = 1'b0;
      n_total++; if (drop_cnt_o !== 8'd4) $display("FAIL drop_both: got %0d want 4", drop_cnt_o); else n_pass++;
      fast_valid_i = 1'b1;
      for (int i = 0; i < 260; i++) tick;
      fast_valid_i = 1'b0;
      n_total++; if (drop_cnt_o !== 8'hFF) $display("FAIL drop_sat: got %h want ff", drop_cnt_o); else n_pass++;
      fifo_full_i = 1'b0;
      for (int i = 0; i < 10; i++) tick;
      n_total++; if (busy_o !== 1'b0) $display("FAIL drop_drain: got %b want 0", busy_o); else n_pass++;
      n_total++; if (drop_cnt_o !== 8'hFF) $display("FAIL drop_hold: got %h want ff", drop_cnt_o); else n_pass++;
   endtask

   task automatic test_invalid_fmt;
      do_reset;
      fast_valid_i = 1'b1; fast_fmt_i = 2'b00; fast_data_i = 24'h123456;
      tick;
      fast_valid_i = 1'b0;
      n_total++; if (busy_o !== 1'b0) $display("FAIL fmt0_busy: got %b want 0", busy_o); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         tick;
         n_total++; if (fifo_wr_en_o !== 1'b0) $display("FAIL fmt0_wr_c%0d: got %b want 0", i, fifo_wr_en_o); else n_pass++;
      end
      n_total++; if (drop_cnt_o !== 8'd1) $display("FAIL fmt0_drop: got %0d want 1", drop_cnt_o); else n_pass++;
   endtask

   task automatic test_enable;
      do_reset;
      enable_i = 1'b0;
      fast_valid_i = 1'b1; fast_fmt_i = 2'b10; fast_data_i = 24'h000333;
      tick;
      fast_valid_i = 1'b0;
      tick;
      n_total++; if (busy_o !== 1'b0) $display("FAIL en_ignore_busy: got %b want 0", busy_o); else n_pass++;
      n_total++; if (drop_cnt_o !== 8'd0) $display("FAIL en_ignore_drop: got %0d want 0", drop_cnt_o); else n_pass++;
      enable_i = 1'b1;
      fast_valid_i = 1'b1; fast_fmt_i = 2'b01; fast_data_i = 24'h111222;
      tick;
      fast_valid_i = 1'b0; enable_i = 1'b0;
      tick; tick;
      n_total++; if ({fifo_wr_en_o, fifo_data_o} !== {1'b1, 14'h0111}) $display("FAIL en_w0: got %b/%h want 1/0111", fifo_wr_en_o, fifo_data_o); else n_pass++;
      tick;
      n_total++; if ({fifo_wr_en_o, fifo_data_o} !== {1'b1, 14'h1222}) $display("FAIL en_w1: got %b/%h want 1/1222", fifo_wr_en_o, fifo_data_o); else n_pass++;
      enable_i = 1'b1;
   endtask

   task automatic test_crc;
      do_reset;
      fast_valid_i = 1'b1; fast_fmt_i = 2'b10; fast_data_i = 24'h000AAA; fast_crc_ok_i = 1'b0;
      tick;
      fast_valid_i = 1'b0; fast_crc_ok_i = 1'b1;
      tick; tick;
`ifdef SENT_RX_STORE_CRC_GATE_EN
      n_total++; if (fifo_wr_en_o !== 1'b0) $display("FAIL crc_gate_wr: got %b want 0", fifo_wr_en_o); else n_pass++;
      n_total++; if (crc_err_cnt_o !== 8'd1) $display("FAIL crc_gate_cnt: got %0d want 1", crc_err_cnt_o); else n_pass++;
      n_total++; if (busy_o !== 1'b0) $display("FAIL crc_gate_busy: got %b want 0", busy_o); else n_pass++;
`else
      n_total++; if ({fifo_wr_en_o, fifo_data_o} !== {1'b1, 14'h0AAA}) $display("FAIL crc_pass_wr: got %b/%h want 1/0aaa", fifo_wr_en_o, fifo_data_o); else n_pass++;
      n_total++; if (crc_err_cnt_o !== 8'd0) $display("FAIL crc_pass_cnt: got %0d want 0", crc_err_cnt_o); else n_pass++;
`endif
      n_total++; if (drop_cnt_o !== 8'd0) $display("FAIL crc_drop: got %0d want 0", drop_cnt_o); else n_pass++;
   endtask

   task automatic test_reset_mid;
      do_reset;
      fast_valid_i = 1'b1; fast_fmt_i = 2'b01; fast_data_i = 24'hDEF456;
      tick;
      fast_valid_i = 1'b0;
      tick; tick;
      n_total++; if ({fifo_wr_en_o, fifo_data_o} !== {1'b1, 14'h0DEF}) $display("FAIL rmid_w0: got %b/%h want 1/0def", fifo_wr_en_o, fifo_data_o); else n_pass++;
      reset_n_rx = 1'b0;
      #1;
      n_total++; if ({fifo_wr_en_o, fifo_data_o, busy_o} !== 16'h0) $display("FAIL rmid_async: got %b/%h/%b want 0/0000/0", fifo_wr_en_o, fifo_data_o, busy_o); else n_pass++;
      tick; tick;
      reset_n_rx = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         n_total++; if ({fifo_wr_en_o, busy_o} !== 2'b00) $display("FAIL rmid_after_c%0d: got wr=%b busy=%b want 0/0", i, fifo_wr_en_o, busy_o); else n_pass++;
      end
   endtask

   initial begin
      test_reset;
      test_two_word;
      test_back_to_back;
      test_fifo_full;
      test_drops;
      test_invalid_fmt;
      test_enable;
      test_crc;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
